// File: rtl/sfp_ctrl.sv
// SFP-stage sequencer: streams OFIFO rows through the SFP into PSUM SRAM over
// n_passes accumulate passes, then an optional in-place ReLU pass.
module sfp_ctrl #(
  parameter int unsigned addr_bw = 11,
  parameter int unsigned pass_bw = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] n_rows,
  input  logic [pass_bw-1:0] n_passes,
  input  logic               relu_en,
  input  logic [addr_bw-1:0] base_addr,
  input  logic               ofifo_valid,
  output logic               ofifo_rd,
  output logic               psum_cen,
  output logic               psum_wen,
  output logic [addr_bw-1:0] psum_addr,
  output logic               accum,
  output logic               zero_psum,
  output logic               busy,
  output logic               done
);

  localparam int unsigned pcnt_bw = pass_bw + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [addr_bw-1:0] idx, idx_nxt;
  logic [pcnt_bw-1:0] pass, pass_nxt;
  logic [addr_bw-1:0] rows_q, base_q;
  logic [pass_bw-1:0] passes_q;
  logic               relu_q;

  logic               cfg_load;
  logic               is_acc;
  logic               last_row;
  logic [pcnt_bw-1:0] pass_inc;
  logic [pcnt_bw-1:0] pass_end;

  assign cfg_load = (state == IDLE) && start;
  assign is_acc   = pass < {1'b0, passes_q};
  assign last_row = idx == (rows_q - addr_bw'(1));
  assign pass_inc = pass + pcnt_bw'(1);
  assign pass_end = {1'b0, passes_q} + pcnt_bw'(relu_q);

  // State, counters and latched config
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      pass     <= '0;
      rows_q   <= '0;
      base_q   <= '0;
      passes_q <= '0;
      relu_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      pass  <= pass_nxt;
      if (cfg_load) begin
        rows_q   <= n_rows;
        base_q   <= base_addr;
        passes_q <= n_passes;
        relu_q   <= relu_en;
      end
    end
  end

  // Next-state and counter update
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    pass_nxt  = pass;
    case (state)
      IDLE: begin
        if (start) begin
          idx_nxt  = '0;
          pass_nxt = '0;
          if ((n_rows == '0) || ((n_passes == '0) && !relu_en)) state_nxt = DONE;
          else                                                 state_nxt = RD;
        end
      end
      RD: begin
        // ReLU pass reads only SRAM, so it never waits on the OFIFO
        if (!is_acc || ofifo_valid) state_nxt = WR;
      end
      WR: begin
        if (last_row) begin
          idx_nxt   = '0;
          pass_nxt  = pass_inc;
          state_nxt = (pass_inc == pass_end) ? DONE : RD;
        end else begin
          idx_nxt   = idx + addr_bw'(1);
          state_nxt = RD;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from registered state (RD strobes gated by ofifo_valid)
  always_comb begin
    ofifo_rd  = 1'b0;
    psum_cen  = 1'b1;
    psum_wen  = 1'b1;
    psum_addr = '0;
    accum     = 1'b0;
    zero_psum = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      RD: begin
        busy      = 1'b1;
        psum_addr = base_q + idx;
        if (is_acc) begin
          ofifo_rd = ofifo_valid;
          psum_cen = ~ofifo_valid;
        end else begin
          psum_cen = 1'b0;
        end
      end
      WR: begin
        busy      = 1'b1;
        psum_addr = base_q + idx;
        psum_cen  = 1'b0;
        psum_wen  = 1'b0;
        accum     = is_acc;
        zero_psum = is_acc && (pass == '0);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sfp_ctrl.sv
// Directed self-checking bench for sfp_ctrl: reset, accumulate+ReLU, stall,
// wrap, degenerate/ignored start and mid-run abort.
module tb_sfp_ctrl;

  localparam int unsigned addr_bw = 11;
  localparam int unsigned pass_bw = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [addr_bw-1:0] n_rows;
  logic [pass_bw-1:0] n_passes;
  logic               relu_en;
  logic [addr_bw-1:0] base_addr;
  logic               ofifo_valid;
  logic               ofifo_rd;
  logic               psum_cen;
  logic               psum_wen;
  logic [addr_bw-1:0] psum_addr;
  logic               accum;
  logic               zero_psum;
  logic               busy;
  logic               done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int pops  = 0;

  always #5 clk = ~clk;

  sfp_ctrl #(.addr_bw(addr_bw), .pass_bw(pass_bw)) dut (
    .clk(clk), .reset(reset), .start(start), .n_rows(n_rows),
    .n_passes(n_passes), .relu_en(relu_en), .base_addr(base_addr),
    .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd), .psum_cen(psum_cen),
    .psum_wen(psum_wen), .psum_addr(psum_addr), .accum(accum),
    .zero_psum(zero_psum), .busy(busy), .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int rd, input int cen, input int wen,
                         input int addr, input int acc, input int zp, input int bsy,
                         input int dn);
    chk({tag, ".ofifo_rd"},  32'(ofifo_rd),  32'(rd));
    chk({tag, ".psum_cen"},  32'(psum_cen),  32'(cen));
    chk({tag, ".psum_wen"},  32'(psum_wen),  32'(wen));
    chk({tag, ".psum_addr"}, 32'(psum_addr), 32'(addr));
    chk({tag, ".accum"},     32'(accum),     32'(acc));
    chk({tag, ".zero_psum"}, 32'(zero_psum), 32'(zp));
    chk({tag, ".busy"},      32'(busy),      32'(bsy));
    chk({tag, ".done"},      32'(done),      32'(dn));
  endtask

  // One full sequence from IDLE; expected per-cycle pattern walks pass/row loops
  task automatic run(input string tag, input int rows, input int passes, input int relu,
                     input int base, input int stall_row, input int stall_len,
                     input int mid_start_cyc, input int exp_done, input int exp_pops);
    int addr;
    n_rows      = addr_bw'(rows);
    n_passes    = pass_bw'(passes);
    relu_en     = 1'(relu);
    base_addr   = addr_bw'(base);
    ofifo_valid = 1'b1;
    start       = 1'b1;
    #1;
    chk_out({tag, ".idle"}, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc  = 0;
    pops = 0;
    step();
    start = 1'b0;
    if (rows > 0 && (passes + relu) > 0) begin
      for (int p = 0; p < passes + relu; p++) begin
        for (int r = 0; r < rows; r++) begin
          addr = (base + r) % 2048;
          if (p == 0 && r == stall_row) begin
            ofifo_valid = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
              #1;
              chk_out({tag, ".stall"}, 0, 1, 1, addr, 0, 0, 1, 0);
              if (ofifo_rd === 1'b1) pops++;
              step();
            end
            ofifo_valid = 1'b1;
          end
          if (cyc == mid_start_cyc) begin
            start    = 1'b1;
            n_rows   = addr_bw'(1);
            n_passes = pass_bw'(0);
            relu_en  = 1'b1;
          end
          #1;
          chk_out({tag, ".rd"}, (p < passes) ? 1 : 0, 0, 1, addr, 0, 0, 1, 0);
          if (ofifo_rd === 1'b1) pops++;
          step();
          start = 1'b0;
          #1;
          chk_out({tag, ".wr"}, 0, 0, 0, addr, (p < passes) ? 1 : 0,
                  (p == 0 && p < passes) ? 1 : 0, 1, 0);
          if (ofifo_rd === 1'b1) pops++;
          step();
        end
      end
    end
    #1;
    chk({tag, ".done_cyc"}, 32'(cyc), 32'(exp_done));
    chk_out({tag, ".done"}, 0, 1, 1, 0, 0, 0, 0, 1);
    chk({tag, ".pops"}, 32'(pops), 32'(exp_pops));
    step();
    chk_out({tag, ".post"}, 0, 1, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b1;
    ofifo_valid = 1'b1;
    n_rows      = addr_bw'(4);
    n_passes    = pass_bw'(2);
    relu_en     = 1'b1;
    base_addr   = addr_bw'(8);

    // Reset held with start and ofifo_valid asserted
    step();
    chk_out("rst0", 0, 1, 1, 0, 0, 0, 0, 0);
    step();
    chk_out("rst1", 0, 1, 1, 0, 0, 0, 0, 0);
    start = 1'b0;
    reset = 1'b1;
    step();
    chk_out("rst_rel", 0, 1, 1, 0, 0, 0, 0, 0);

    // 4 rows x (2 acc + ReLU) at base 8: 8 pops, done at cycle 25
    run("basic", 4, 2, 1, 8, -1, 0, -1, 25, 8);
    // Five stall cycles ahead of the row-2 read: done at cycle 30
    run("stall", 4, 2, 1, 8, 2, 5, -1, 30, 8);
    // start pulsed mid-run with different config must be ignored
    run("midstart", 4, 2, 1, 8, -1, 0, 5, 25, 8);
    // Address wrap 2046..1
    run("wrap", 4, 1, 0, 2046, -1, 0, -1, 9, 4);
    // Degenerate configs finish in one cycle with no access
    run("rows0", 0, 2, 1, 8, -1, 0, -1, 1, 0);
    run("pass0", 3, 0, 0, 8, -1, 0, -1, 1, 0);
    // ReLU-only pass: no pops, accum low
    run("relu_only", 2, 0, 1, 100, -1, 0, -1, 5, 0);

    // Abort during pass-1 WR of row 0 (cycle 10)
    n_rows      = addr_bw'(4);
    n_passes    = pass_bw'(2);
    relu_en     = 1'b1;
    base_addr   = addr_bw'(8);
    ofifo_valid = 1'b1;
    start       = 1'b1;
    #1;
    cyc = 0;
    step();
    start = 1'b0;
    repeat (9) step();
    #1;
    chk("abort.cyc", 32'(cyc), 32'(10));
    chk_out("abort_pre", 0, 0, 0, 8, 1, 0, 1, 0);
    reset = 1'b0;
    step();
    chk_out("abort_rst", 0, 1, 1, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    chk_out("abort_idle", 0, 1, 1, 0, 0, 0, 0, 0);
    run("after_abort", 4, 2, 1, 8, -1, 0, -1, 25, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sfp_ctrl.md
Name: sfp_ctrl

Overview:
- Sequencer for the SFP stage: moves OFIFO output rows through the SFP and into the PSUM SRAM.
- Runs n_passes accumulate passes, one per kernel offset (kij), each doing psum[a] = psum[a] + ofifo.
- Then optionally runs one in-place ReLU pass over the same address range.
- Drives the single-port PSUM SRAM (active-low CEN/WEN, 1-cycle read latency), the OFIFO read strobe and the SFP accum select.

Parameters:
addr_bw, 11, PSUM SRAM address width
pass_bw, 4, width of pass count

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  pulse; latches config and begins sequence (accepted in IDLE only)
n_rows  in  addr_bw  rows per pass
n_passes  in  pass_bw  number of accumulate passes
relu_en  in  1  append ReLU pass
base_addr  in  addr_bw  first PSUM SRAM address
ofifo_valid  in  1  OFIFO has a row available
ofifo_rd  out  1  OFIFO pop; data valid next cycle
psum_cen  out  1  SRAM chip enable, active low
psum_wen  out  1  SRAM write enable, active low
psum_addr  out  addr_bw  SRAM address
accum  out  1  SFP mode: 1 = accumulate, 0 = ReLU
zero_psum  out  1  datapath forces psum_in to 0 (first accumulate pass; SRAM contents undefined)
busy  out  1  high in RD/WR
done  out  1  one-cycle completion pulse

Behaviour:
- Registers:
  - state: IDLE, RD, WR, DONE.
  - idx (addr_bw).
  - pass (pass_bw+1).
  - Latched copies of n_rows, n_passes, relu_en and base_addr.
  - Outputs are decoded combinationally from the registered state. The only exception is gating by ofifo_valid.
- Reset (reset==0 at clk edge):
  - state=IDLE, idx=0, pass=0.
  - Outputs: ofifo_rd=0, psum_cen=1, psum_wen=1, psum_addr=0, accum=0, zero_psum=0, busy=0, done=0.
  - Reset mid-operation aborts immediately with no further SRAM or OFIFO access.
- IDLE:
  - All outputs at reset values.
  - On start: latch config; idx=0, pass=0.
  - If n_rows==0, or n_passes==0 with relu_en==0, go to DONE. Otherwise go to RD.
- Pass type: an accumulate pass when pass<n_passes, else the ReLU pass.
- psum_addr in RD/WR = (base_addr+idx) mod 2^addr_bw. Wrap-around is legal.
- RD, accumulate pass:
  - ofifo_rd=ofifo_valid, psum_cen=~ofifo_valid, psum_wen=1.
  - ofifo_valid=0: stall in RD with no access.
  - ofifo_valid=1: go to WR.
- RD, ReLU pass:
  - psum_cen=0, psum_wen=1, ofifo_rd=0.
  - Go to WR unconditionally.
- WR:
  - psum_cen=0, psum_wen=0, same address as the preceding RD.
  - SRAM Q and OFIFO data are valid this cycle, so sfp_out is written back.
  - accum=(pass<n_passes).
  - zero_psum=(pass==0 && accum).
- WR exit:
  - If idx==n_rows-1: idx=0, pass=pass+1. If the new pass equals n_passes+relu_en, go to DONE; else go to RD.
  - Otherwise idx=idx+1 and go to RD.
- DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Throughput and latency:
  - 2 cycles/row with no stalls.
  - From the start edge to the done-high cycle: 2*n_rows*(n_passes+relu_en)+1 cycles.
- start while not in IDLE is ignored. Config inputs are sampled only on the accepted start.
- Never assert psum_wen=0 together with ofifo_rd=1.
- Never pop the OFIFO during the ReLU pass.

Test Plan:
- Reset values: reset low for 2 cycles, with start=1 and ofifo_valid=1 -> all outputs at reset values, no SRAM access.
- Basic accumulate + ReLU: n_rows=4, n_passes=2, relu_en=1, base=8, ofifo_valid=1 -> required response:
  - 8 ofifo_rd pulses.
  - Addresses 8,8,9,9…11,11 repeated over 3 passes.
  - zero_psum high only on pass-0 WRs.
  - accum=0 on the last 4 WRs.
  - done one cycle, 25 cycles after start.
- Stall: same config, ofifo_valid low for 5 cycles before the row-2 RD -> FSM holds RD with psum_cen=1 and no pop; done arrives 5 cycles later (30).
- Wrap: base=2046, n_rows=4, addr_bw=11, n_passes=1, relu_en=0 -> addresses 2046,2047,0,1; done at cycle 9.
- Degenerate/ignored start: n_rows=0 -> done 1 cycle after start, no access. start pulsed mid-run -> no effect on sequence.
- Abort: reset low during pass 1 WR -> next cycle IDLE values. A following start runs cleanly from idx=0, pass=0.
